mem_port_arbiter: RTL

- Shares one single-port unified instruction/data memory between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Issues one memory transaction at a time and counts the fixed memory read latency.
- Returns responses to the correct requester and raises cpu_stall while any active request is unanswered.
- Sits between fetch_top/memory_top and the shared RAM macro.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: serialises fetch reads and data loads/stores onto one RAM port.
// Optional ARB_RR_EN: round-robin tie-breaking instead of fixed data-over-fetch priority.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  cpu_stall
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    localparam logic [3:0] LatCnt = 4'(MEM_LAT);

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            owner_q;  // 1 = data port, 0 = fetch port
    logic            store_q;

    logic                  any_req;
    logic                  grant_data;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [3:0]            sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  unused_addr_bits;

`ifdef ARB_RR_EN
    logic last_owner_q;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        grant_data = d_req & ~(if_req & last_owner_q);
    end
`else
    always_comb begin
        grant_data = d_req;
    end
`endif

    always_comb begin
        any_req   = if_req | d_req;
        sel_addr  = grant_data ? d_addr : if_addr;
        sel_we    = grant_data & d_we;
        sel_be    = sel_we ? d_be : 4'hF;
        sel_wdata = sel_we ? d_wdata : '0;
    end

    // Byte offset bits never reach the word-addressed RAM.
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            store_q   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
`ifdef ARB_RR_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q   <= StIssue;
                        cnt_q     <= LatCnt;
                        owner_q   <= grant_data;
                        store_q   <= sel_we;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_be    <= sel_be;
                        mem_addr  <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata <= sel_wdata;
`ifdef ARB_RR_EN
                        last_owner_q <= grant_data;
`endif
                    end
                end
                StIssue, StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StWait;
                        cnt_q   <= cnt_q - 4'd1;
                        // Counter about to hit zero: next cycle is the response cycle.
                        if (cnt_q == 4'd1) begin
                            if_valid <= ~owner_q;
                            d_valid  <= owner_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        if_rdata  = if_valid ? mem_rdata : '0;
        d_rdata   = (d_valid && !store_q) ? mem_rdata : '0;
        cpu_stall = (if_req & ~if_valid) | (d_req & ~d_valid);
    end

endmodule
